// File: rtl/scope_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scope_pkg : shared state, mode and slope encodings for the        |
// |             oscilloscope trigger/capture sequencer                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package scope_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/scope_trig_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scope_trig_detect : level-crossing detector on the sample stream  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    output logic              hit
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              rise, fall;

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear) begin
            prev_valid_d = 1'b0;
        end else if (sample_en) begin
            prev_d       = data_in;
            prev_valid_d = 1'b1;
        end
    end

    // A crossing needs a previous sample from the current arm window.
    always_comb begin
        rise = prev_valid_q && (prev_q < level) && (data_in >= level);
        fall = prev_valid_q && (prev_q > level) && (data_in <= level);
        hit  = sample_en && !clear && ((slope == SLOPE_FALL) ? fall : rise);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scope_trigger_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scope_trigger_ctrl : trigger and capture sequencer writing one    |
// |                      screen record into a ping-pong buffer        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module scope_trigger_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int TMO_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic [TMO_W-1:0]  auto_timeout,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              resample,
    output logic              triggered,
    output logic [1:0]        state_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_bank_q, wr_bank_d;
    logic              resample_q, resample_d;
    logic              triggered_q, triggered_d;
    logic              det_clear, det_hit, forced;

    // Detector history is held clear whenever we are not waiting for a trigger.
    assign det_clear = (state_q != WAIT_TRIG);

    scope_trig_detect #(
        .DATA_W (DATA_W)
    ) u_detect (
        .clock     (clock),
        .reset     (reset),
        .sample_en (sample_en),
        .clear     (det_clear),
        .data_in   (data_in),
        .level     (trig_level),
        .slope     (trig_slope),
        .hit       (det_hit)
    );

    // Saturating tick count; ">=" also makes a zero timeout fire on the first tick.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
    assign forced  = sample_en && (state_q == WAIT_TRIG) && (mode_q == MODE_AUTO)
                     && (cnt_inc >= auto_timeout);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        cnt_d       = (state_q == WAIT_TRIG) ? cnt_q : '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_bank_d   = wr_bank_q;
        resample_d  = 1'b0;
        triggered_d = triggered_q;

        case (state_q)
            IDLE: begin
                if ((trig_mode != MODE_SINGLE) || arm) begin
                    mode_d  = trig_mode;
                    state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (sample_en && (mode_q == MODE_AUTO)) begin
                    cnt_d = cnt_inc;
                end
                if (det_hit || forced) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = data_in;
                    addr_d      = ADDR_W'(1);
                    triggered_d = 1'b1;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_en) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = data_in;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                if (frame_done) begin
                    wr_bank_d   = ~wr_bank_q;
                    resample_d  = 1'b1;
                    triggered_d = 1'b0;
                    state_d     = (mode_q == MODE_SINGLE) ? IDLE : WAIT_TRIG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_AUTO;
            addr_q      <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_bank_q   <= 1'b0;
            resample_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_bank_q   <= wr_bank_d;
            resample_q  <= resample_d;
            triggered_q <= triggered_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_bank   = wr_bank_q;
    assign rd_bank   = ~wr_bank_q;
    assign resample  = resample_q;
    assign triggered = triggered_q;
    assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_scope_trigger_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_scope_trigger_ctrl : self-checking bench for the trigger and   |
// |                         capture sequencer                         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_scope_trigger_ctrl;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 640;
    localparam int ADDR_W = 10;
    localparam int TMO_W  = 16;

    typedef logic [DATA_W-1:0] samp_t;
    typedef logic [ADDR_W+DATA_W-1:0] wrec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              trig_slope = 1'b0;
    logic [1:0]        trig_mode = 2'd1;
    logic              arm = 1'b0;
    logic [TMO_W-1:0]  auto_timeout = '0;
    logic              frame_done = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_bank;
    logic              rd_bank;
    logic              resample;
    logic              triggered;
    logic [1:0]        state_out;

    int    total = 0;
    int    bad = 0;
    int    n_resample = 0;
    wrec_t wq[$];

    always #10 clock = ~clock;

    scope_trigger_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_en    (sample_en),
        .data_in      (data_in),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .trig_mode    (trig_mode),
        .arm          (arm),
        .auto_timeout (auto_timeout),
        .frame_done   (frame_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .resample     (resample),
        .triggered    (triggered),
        .state_out    (state_out)
    );

    // Buffer-side observer: every write and every publish pulse.
    always @(negedge clock) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (resample) n_resample++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick(input samp_t v);
        sample_en = 1'b1;
        data_in   = v;
        @(negedge clock);
        sample_en = 1'b0;
    endtask

    task automatic gap();
        cyc($urandom_range(0, 2));
    endtask

    task automatic feed(input samp_t s[$], input int from, input int to);
        for (int i = from; i < to; i++) begin
            tick(s[i]);
            gap();
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sample_en  = 1'b0;
        frame_done = 1'b0;
        arm        = 1'b0;
        cyc(2);
        reset = 1'b0;
        wq.delete();
        n_resample = 0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
    endtask

    // Reference: index of the triggering sample in a stream seen after arming.
    function automatic int find_trig(input samp_t s[$], input samp_t lvl, input logic slope,
                                     input logic is_auto, input int tmo);
        for (int i = 0; i < s.size(); i++) begin
            if (is_auto && (i + 1 >= tmo)) return i;
            if (i > 0) begin
                if (!slope && (s[i-1] < lvl) && (s[i] >= lvl)) return i;
                if (slope && (s[i-1] > lvl) && (s[i] <= lvl)) return i;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        trig_mode = 2'd1;
        reset = 1'b1;
        cyc(2);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data: got %0d expected 0", wr_data); end
        total++; if (wr_bank !== 1'b0) begin bad++; $display("FAIL reset_wr_bank: got %0b expected 0", wr_bank); end
        total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL reset_rd_bank: got %0b expected 1", rd_bank); end
        total++; if (resample !== 1'b0) begin bad++; $display("FAIL reset_resample: got %0b expected 0", resample); end
        total++; if (triggered !== 1'b0) begin bad++; $display("FAIL reset_triggered: got %0b expected 0", triggered); end
        total++; if (state_out !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        reset = 1'b0;
        cyc(1);
        total++; if (state_out !== 2'd1) begin bad++; $display("FAIL reset_exit_state: got %0d expected 1", state_out); end
    endtask

    task automatic test_rising();
        trig_mode = 2'd1; trig_level = 12'd2048; trig_slope = 1'b0;
        do_reset();
        cyc(1);
        tick(12'd2000); cyc(1);
        tick(12'd2040); cyc(1);
        total++; if (wq.size() != 0) begin bad++; $display("FAIL rise_early_writes: got %0d expected 0", wq.size()); end
        tick(12'd2050);
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rise_wr_en: got %0b expected 1", wr_en); end
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL rise_wr_addr: got %0d expected 0", wr_addr); end
        total++; if (wr_data !== 12'd2050) begin bad++; $display("FAIL rise_wr_data: got %0d expected 2050", wr_data); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL rise_triggered: got %0b expected 1", triggered); end
        total++; if (state_out !== 2'd2) begin bad++; $display("FAIL rise_state: got %0d expected 2", state_out); end
        cyc(1);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rise_one_cycle: got %0b expected 0", wr_en); end
    endtask

    task automatic test_full_record();
        samp_t s[$];
        int    nerr = 0;
        wq.delete();
        for (int k = 0; k < DEPTH; k++) s.push_back(samp_t'($urandom_range(0, 4095)));
        feed(s, 1, DEPTH - 1);
        sample_en = 1'b1; frame_done = 1'b1; data_in = s[DEPTH-1];
        @(negedge clock);
        sample_en = 1'b0; frame_done = 1'b0;
        total++; if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(DEPTH - 1) || wr_data !== s[DEPTH-1]) begin
            bad++; $display("FAIL full_last_write: got en=%0b addr=%0d data=%0d expected en=1 addr=639 data=%0d",
                            wr_en, wr_addr, wr_data, s[DEPTH-1]);
        end
        total++; if (state_out !== 2'd3) begin bad++; $display("FAIL full_done_state: got %0d expected 3", state_out); end
        cyc(3);
        total++; if (n_resample != 0 || wr_bank !== 1'b0) begin
            bad++; $display("FAIL full_entry_frame_ignored: got resample=%0d bank=%0b expected 0 0", n_resample, wr_bank);
        end
        tick(12'd77); cyc(1);
        total++; if (wq.size() != DEPTH - 1) begin bad++; $display("FAIL full_count: got %0d expected %0d", wq.size(), DEPTH - 1); end
        for (int k = 1; k < DEPTH && k - 1 < wq.size(); k++) begin
            logic [ADDR_W-1:0] a;
            a = k[ADDR_W-1:0];
            if (wq[k-1] !== {a, s[k]}) nerr++;
        end
        total++; if (nerr != 0) begin bad++; $display("FAIL full_contents: got %0d wrong entries expected 0", nerr); end
        total++; if (state_out !== 2'd3) begin bad++; $display("FAIL full_hold_done: got %0d expected 3", state_out); end
        pulse_frame();
        total++; if (resample !== 1'b1) begin bad++; $display("FAIL pub_resample: got %0b expected 1", resample); end
        total++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin
            bad++; $display("FAIL pub_banks: got wr=%0b rd=%0b expected wr=1 rd=0", wr_bank, rd_bank);
        end
        total++; if (triggered !== 1'b0) begin bad++; $display("FAIL pub_triggered: got %0b expected 0", triggered); end
        total++; if (state_out !== 2'd1) begin bad++; $display("FAIL pub_state: got %0d expected 1", state_out); end
        cyc(1);
        total++; if (resample !== 1'b0) begin bad++; $display("FAIL pub_one_cycle: got %0b expected 0", resample); end
    endtask

    task automatic test_auto();
        trig_mode = 2'd0; trig_level = 12'd4000; trig_slope = 1'b0; auto_timeout = 16'd5;
        do_reset();
        cyc(1);
        for (int i = 0; i < 4; i++) begin tick(12'd100); gap(); end
        cyc(1);
        total++; if (wq.size() != 0) begin bad++; $display("FAIL auto_early: got %0d writes expected 0", wq.size()); end
        tick(12'd100);
        total++; if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 12'd100) begin
            bad++; $display("FAIL auto_tmo5: got en=%0b addr=%0d data=%0d expected en=1 addr=0 data=100", wr_en, wr_addr, wr_data);
        end
        auto_timeout = 16'd0;
        do_reset();
        cyc(1);
        tick(12'd100);
        total++; if (wr_en !== 1'b1 || wr_addr !== '0) begin
            bad++; $display("FAIL auto_tmo0: got en=%0b addr=%0d expected en=1 addr=0", wr_en, wr_addr);
        end
    endtask

    task automatic test_falling();
        trig_mode = 2'd1; trig_level = 12'd1000; trig_slope = 1'b1;
        do_reset();
        cyc(1);
        tick(12'd900); cyc(1);
        tick(12'd1100); cyc(1);
        total++; if (wq.size() != 0) begin bad++; $display("FAIL fall_early: got %0d writes expected 0", wq.size()); end
        tick(12'd950);
        total++; if (wr_en !== 1'b1 || wr_data !== 12'd950) begin
            bad++; $display("FAIL fall_trig: got en=%0b data=%0d expected en=1 data=950", wr_en, wr_data);
        end
    endtask

    task automatic test_single();
        samp_t s[$];
        trig_mode = 2'd2; trig_level = 12'd2048; trig_slope = 1'b0;
        do_reset();
        for (int i = 0; i < 100; i++) tick((i % 2) ? 12'd4095 : 12'd0);
        cyc(1);
        total++; if (wq.size() != 0 || state_out !== 2'd0) begin
            bad++; $display("FAIL single_idle: got writes=%0d state=%0d expected 0 0", wq.size(), state_out);
        end
        arm = 1'b1; @(negedge clock); arm = 1'b0;
        total++; if (state_out !== 2'd1) begin bad++; $display("FAIL single_arm: got %0d expected 1", state_out); end
        tick(12'd0); tick(12'd4095);
        total++; if (wr_en !== 1'b1 || state_out !== 2'd2) begin
            bad++; $display("FAIL single_trig: got en=%0b state=%0d expected 1 2", wr_en, state_out);
        end
        for (int k = 0; k < DEPTH; k++) s.push_back(samp_t'($urandom_range(0, 4095)));
        feed(s, 1, 301);
        arm = 1'b1; @(negedge clock); arm = 1'b0;
        feed(s, 301, DEPTH);
        cyc(1);
        total++; if (wq.size() != DEPTH || state_out !== 2'd3) begin
            bad++; $display("FAIL single_record: got writes=%0d state=%0d expected %0d 3", wq.size(), state_out, DEPTH);
        end
        pulse_frame();
        total++; if (resample !== 1'b1 || state_out !== 2'd0 || wr_bank !== 1'b1) begin
            bad++; $display("FAIL single_publish: got rs=%0b state=%0d bank=%0b expected 1 0 1", resample, state_out, wr_bank);
        end
        wq.delete();
        for (int i = 0; i < 20; i++) tick((i % 2) ? 12'd4095 : 12'd0);
        cyc(1);
        total++; if (wq.size() != 0 || state_out !== 2'd0 || n_resample != 1) begin
            bad++; $display("FAIL single_rearm_needed: got writes=%0d state=%0d rs=%0d expected 0 0 1", wq.size(), state_out, n_resample);
        end
    endtask

    task automatic test_reset_mid();
        samp_t s[$];
        trig_mode = 2'd1; trig_level = 12'd2048; trig_slope = 1'b0;
        do_reset();
        cyc(1);
        tick(12'd0); tick(12'd4095);
        for (int k = 0; k < 300; k++) s.push_back(samp_t'($urandom_range(0, 4095)));
        feed(s, 1, 300);
        #3 reset = 1'b1;
        #1;
        total++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || resample !== 1'b0) begin
            bad++; $display("FAIL mid_reset_write: got en=%0b addr=%0d data=%0d rs=%0b expected 0 0 0 0", wr_en, wr_addr, wr_data, resample);
        end
        total++; if (triggered !== 1'b0 || state_out !== 2'd0) begin
            bad++; $display("FAIL mid_reset_state: got trig=%0b state=%0d expected 0 0", triggered, state_out);
        end
        total++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
            bad++; $display("FAIL mid_reset_banks: got wr=%0b rd=%0b expected 0 1", wr_bank, rd_bank);
        end
        trig_mode = 2'd2;
        cyc(2);
        reset = 1'b0;
        n_resample = 0;
        cyc(5);
        total++; if (n_resample != 0 || wr_bank !== 1'b0) begin
            bad++; $display("FAIL mid_reset_no_publish: got rs=%0d bank=%0b expected 0 0", n_resample, wr_bank);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] latched;
        logic       exp_bank;
        int         mode_pick;
        mode_pick = $urandom_range(0, 2);
        latched   = (mode_pick == 0) ? 2'd0 : (mode_pick == 1) ? 2'd1 : 2'd3;
        trig_mode = latched;
        do_reset();
        exp_bank = 1'b0;
        cyc(1);
        for (int r = 0; r < 4; r++) begin
            samp_t s[$];
            samp_t lvl;
            logic  slp;
            int    tmo, trig, nerr;
            lvl = samp_t'($urandom_range(500, 3500));
            slp = 1'($urandom_range(0, 1));
            tmo = $urandom_range(3, 40);
            trig_level = lvl; trig_slope = slp; auto_timeout = TMO_W'(tmo);
            for (int i = 0; i < 48; i++) s.push_back(samp_t'($urandom_range(0, 4095)));
            trig = find_trig(s, lvl, slp, latched == 2'd0, tmo);
            if (trig < 0) begin
                s.push_back(slp ? 12'd4095 : 12'd0);
                s.push_back(slp ? 12'd0 : 12'd4095);
                trig = find_trig(s, lvl, slp, latched == 2'd0, tmo);
            end
            while (s.size() > trig + 1) void'(s.pop_back());
            for (int k = 1; k < DEPTH; k++) s.push_back(samp_t'($urandom_range(0, 4095)));
            feed(s, 0, trig + 10);
            trig_mode = 2'($urandom_range(0, 3));
            feed(s, trig + 10, s.size());
            cyc(1);
            total++; if (wq.size() != DEPTH) begin bad++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", r, wq.size(), DEPTH); end
            nerr = 0;
            for (int k = 0; k < DEPTH && k < wq.size(); k++) begin
                logic [ADDR_W-1:0] a;
                a = k[ADDR_W-1:0];
                if (wq[k] !== {a, s[trig+k]}) nerr++;
            end
            total++; if (nerr != 0) begin bad++; $display("FAIL b2b_contents[%0d]: got %0d wrong entries expected 0", r, nerr); end
            pulse_frame();
            exp_bank = ~exp_bank;
            total++; if (resample !== 1'b1 || wr_bank !== exp_bank || rd_bank !== ~exp_bank || state_out !== 2'd1) begin
                bad++; $display("FAIL b2b_publish[%0d]: got rs=%0b wr=%0b rd=%0b state=%0d expected 1 %0b %0b 1",
                                r, resample, wr_bank, rd_bank, state_out, exp_bank, ~exp_bank);
            end
            wq.delete();
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_full_record();
        test_auto();
        test_falling();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
